// File: rtl/bg_pattern_gen.sv
// ---------------------------------------------------------------------------
// bg_pattern_gen
//
// Background pattern generator for a raster display. For each raster
// coordinate it produces an 8-bit RRRGGGBB colour two clock cycles later.
// The picture is built from, highest priority first: a colour matrix, bracket
// lines inset from the frame, the frame border and a flat default fill. Four
// display modes are selected through a valid/ready request that takes effect
// at the next frame start, so a frame never changes mode half-way through.
//
// Optional feature: define BG_BLINK_EN to make the bracket lines blink, with
// 16 frames off followed by 16 frames on. Without the macro the bracket lines
// are always drawn and no blink counter exists.
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   asynchronous reset, active high
//   pixelX, pixelY  in   11-bit raster coordinate
//   mode_req        in   requested display mode
//   mode_valid      in   mode request valid
//   mode_ready      out  a new mode request can be accepted
//   BG_RGB          out  pixel colour RRRGGGBB, 2-cycle latency
//   boardersDrawReq out  high while a bracket-line pixel is output
//   frame_start     out  one-cycle pulse, 1 cycle after (0,0) is sampled
//
// Display modes
//   mode        | meaning
//   MODE_BG     | background only: brackets, border, fill (no matrix)
//   MODE_STATIC | matrix drawn with scroll offset forced to 0
//   MODE_SCROLL | matrix colour advances once every SCROLL_PERIOD frames
//   MODE_BLANK  | all pixels 0, no bracket requests
// ---------------------------------------------------------------------------
module bg_pattern_gen #(
    parameter int FRAME_W        = 635,
    parameter int FRAME_H        = 475,
    parameter int BRACKET_OFFSET = 30,
    parameter int CELL_LOG2      = 3,
    parameter int MATRIX_CELLS   = 16,
    parameter int MATRIX_LEFT_X  = 100,
    parameter int MATRIX_TOP_Y   = 100,
    parameter int SCROLL_PERIOD  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [1:0]  mode_req,
    input  logic        mode_valid,
    output logic        mode_ready,
    output logic [7:0]  BG_RGB,
    output logic        boardersDrawReq,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        MODE_BG     = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    localparam int MATRIX_SPAN = MATRIX_CELLS << CELL_LOG2;

    // All geometry is compared on 12 bits so that sums near the top of the
    // 11-bit coordinate range cannot wrap.
    localparam logic [11:0] FW_C     = 12'(FRAME_W);
    localparam logic [11:0] FH_C     = 12'(FRAME_H);
    localparam logic [11:0] BR_LEFT  = 12'(BRACKET_OFFSET);
    localparam logic [11:0] BR_RIGHT = 12'(FRAME_W - BRACKET_OFFSET);
    localparam logic [11:0] BR_TOP   = 12'(BRACKET_OFFSET);
    localparam logic [11:0] BR_BOT   = 12'(FRAME_H - BRACKET_OFFSET);
    localparam logic [11:0] MX_LEFT  = 12'(MATRIX_LEFT_X);
    localparam logic [11:0] MX_RIGHT = 12'(MATRIX_LEFT_X + MATRIX_SPAN);
    localparam logic [11:0] MX_TOP   = 12'(MATRIX_TOP_Y);
    localparam logic [11:0] MX_BOT   = 12'(MATRIX_TOP_Y + MATRIX_SPAN);
    localparam logic [7:0]  CNT_LAST = 8'(SCROLL_PERIOD - 1);

    localparam logic [7:0] COL_BRACKET = 8'hFF;
    localparam logic [7:0] COL_BORDER  = 8'hFC;
    localparam logic [7:0] COL_FILL    = 8'h58;

    // stage 1
    logic [10:0] x1_q, y1_q;
    logic        v1_q;
    logic        prev_org_q;
    logic        fs_q;

    // mode handshake
    mode_e       mode_q, mode_d;
    mode_e       pend_mode_q;
    logic        pend_valid_q;
    logic        ready_q;
    logic        ready_rel_q;

    // scroll state
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  scroll_q, scroll_d;

    // stage 2 (outputs)
    logic [7:0]  rgb_q, rgb_d;
    logic        brd_q, brd_d;

    logic        bracket_en;

`ifdef BG_BLINK_EN
    logic [4:0]  blink_q;
    assign bracket_en = blink_q[4];
`else
    assign bracket_en = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Frame start detection and mode request control
    // -----------------------------------------------------------------------
    logic org_hit, fs_d, capture, apply;
    logic enter_scroll, stay_scroll;

    assign org_hit = (pixelX == 11'd0) && (pixelY == 11'd0);
    assign fs_d    = org_hit && !prev_org_q;
    assign capture = mode_valid && ready_q;
    // A capture on the frame-start edge sees pend_valid_q still low, so it
    // naturally waits for the following frame start.
    assign apply   = fs_d && pend_valid_q;

    always_comb begin
        mode_d = mode_q;
        if (apply) begin
            mode_d = pend_mode_q;
        end
    end

    assign enter_scroll = (mode_d == MODE_SCROLL) && (mode_q != MODE_SCROLL);
    assign stay_scroll  = (mode_d == MODE_SCROLL) && (mode_q == MODE_SCROLL);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        scroll_d    = scroll_q;
        if (fs_d) begin
            if (enter_scroll) begin
                frame_cnt_d = 8'd0;
                scroll_d    = 8'd0;
            end else if (stay_scroll) begin
                if (frame_cnt_q == CNT_LAST) begin
                    frame_cnt_d = 8'd0;
                    scroll_d    = scroll_q + 8'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 colour selection
    // -----------------------------------------------------------------------
    logic [11:0] x12, y12;
    logic        in_frame, in_matrix, on_bracket, on_border;
    logic [3:0]  cell_x, cell_y;
    logic [7:0]  scroll_eff, matrix_col;

    assign x12 = {1'b0, x1_q};
    assign y12 = {1'b0, y1_q};

    assign in_frame  = (x12 <= FW_C) && (y12 <= FH_C);
    assign in_matrix = (x12 > MX_LEFT) && (x12 < MX_RIGHT) &&
                       (y12 > MX_TOP)  && (y12 < MX_BOT);

    assign on_bracket = (((x12 == BR_LEFT) || (x12 == BR_RIGHT)) &&
                         (y12 >= BR_TOP) && (y12 <= BR_BOT)) ||
                        (((y12 == BR_TOP) || (y12 == BR_BOT)) &&
                         (x12 >= BR_LEFT) && (x12 <= BR_RIGHT));

    assign on_border = (x12 == 12'd0) || (y12 == 12'd0) ||
                       (x12 == FW_C)  || (y12 == FH_C);

    // Cell index only matters inside the matrix, where it is below 16.
    assign cell_x = 4'((x12 - MX_LEFT) >> CELL_LOG2);
    assign cell_y = 4'((y12 - MX_TOP) >> CELL_LOG2);

    assign scroll_eff = (mode_q == MODE_SCROLL) ? scroll_q : 8'd0;
    assign matrix_col = {cell_y, cell_x} + scroll_eff;

    always_comb begin
        rgb_d = 8'h00;
        brd_d = 1'b0;
        if (!v1_q || (mode_q == MODE_BLANK)) begin
            rgb_d = 8'h00;
        end else if (!in_frame) begin
            rgb_d = COL_FILL;
        end else if ((mode_q != MODE_BG) && in_matrix) begin
            rgb_d = matrix_col;
        end else if (on_bracket && bracket_en) begin
            rgb_d = COL_BRACKET;
            brd_d = 1'b1;
        end else if (on_border) begin
            rgb_d = COL_BORDER;
        end else begin
            rgb_d = COL_FILL;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1_q         <= '0;
            y1_q         <= '0;
            v1_q         <= 1'b0;
            prev_org_q   <= 1'b0;
            fs_q         <= 1'b0;
            mode_q       <= MODE_STATIC;
            pend_mode_q  <= MODE_BG;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            ready_rel_q  <= 1'b0;
            frame_cnt_q  <= '0;
            scroll_q     <= '0;
            rgb_q        <= '0;
            brd_q        <= 1'b0;
`ifdef BG_BLINK_EN
            blink_q      <= '0;
`endif
        end else begin
            x1_q        <= pixelX;
            y1_q        <= pixelY;
            v1_q        <= 1'b1;
            prev_org_q  <= org_hit;
            fs_q        <= fs_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            scroll_q    <= scroll_d;
            rgb_q       <= rgb_d;
            brd_q       <= brd_d;

            // ready is low whenever a request is pending, so capture and
            // apply never fall on the same edge.
            if (capture) begin
                pend_mode_q  <= mode_e'(mode_req);
                pend_valid_q <= 1'b1;
                ready_q      <= 1'b0;
            end else if (apply) begin
                pend_valid_q <= 1'b0;
                ready_rel_q  <= 1'b1;
            end else if (ready_rel_q) begin
                ready_q      <= 1'b1;
                ready_rel_q  <= 1'b0;
            end

`ifdef BG_BLINK_EN
            if (fs_d) begin
                blink_q <= blink_q + 5'd1;
            end
`endif
        end
    end

    assign BG_RGB          = rgb_q;
    assign boardersDrawReq = brd_q;
    assign frame_start     = fs_q;
    assign mode_ready      = ready_q;

endmodule

// File: tb/tb_bg_pattern_gen.sv
module tb_bg_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pixelX, pixelY;
    logic [1:0]  mode_req;
    logic        mode_valid;
    logic        mode_ready;
    logic [7:0]  BG_RGB;
    logic        boardersDrawReq;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    bg_pattern_gen dut (
        .clk            (clk),
        .reset          (reset),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .mode_req       (mode_req),
        .mode_valid     (mode_valid),
        .mode_ready     (mode_ready),
        .BG_RGB         (BG_RGB),
        .boardersDrawReq(boardersDrawReq),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one coordinate, queue its expected {boardersDrawReq, BG_RGB},
    // and compare once the pipeline delivers it two edges later.
    task automatic pix(input string tag, input int x, input int y,
                       input logic [7:0] rgb, input logic brd);
        logic [8:0] e;
        pixelX = 11'(x);
        pixelY = 11'(y);
        exp_q.push_back({brd, rgb});
        step();
        step();
        e = exp_q.pop_front();
        chk(tag, {23'd0, boardersDrawReq, BG_RGB}, {23'd0, e});
    endtask

    task automatic new_frame();
        pixelX = 11'd0;
        pixelY = 11'd0;
        step();
        chk("frame_start", 32'(frame_start), 32'd1);
        pixelX = 11'd5;
        pixelY = 11'd5;
        step();
        chk("frame_start_pulse", 32'(frame_start), 32'd0);
    endtask

    // Request a mode mid-frame and follow the handshake through the frame start.
    task automatic change_mode(input logic [1:0] m);
        chk("ready_before_req", 32'(mode_ready), 32'd1);
        pixelX = 11'd7;
        pixelY = 11'd7;
        mode_req   = m;
        mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        chk("ready_drop", 32'(mode_ready), 32'd0);
        step();
        step();
        chk("ready_hold", 32'(mode_ready), 32'd0);
        pixelX = 11'd0;
        pixelY = 11'd0;
        step();
        chk("mode_fs", 32'(frame_start), 32'd1);
        chk("ready_at_fs", 32'(mode_ready), 32'd0);
        pixelX = 11'd5;
        pixelY = 11'd5;
        step();
        chk("ready_after_fs", 32'(mode_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        pixelX     = 11'd3;
        pixelY     = 11'd3;
        mode_req   = 2'd0;
        mode_valid = 1'b0;
        #2;
        chk("rst_rgb", 32'(BG_RGB), 32'd0);
        chk("rst_brd", 32'(boardersDrawReq), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ready", 32'(mode_ready), 32'd1);
        step();
        step();
        chk("rst_hold_rgb", 32'(BG_RGB), 32'd0);
        reset = 1'b0;

        // Bracket, border, clipping in the reset mode (static matrix)
`ifdef BG_BLINK_EN
        pix("blink_off", 30, 200, 8'h58, 1'b0);
        repeat (16) new_frame();
        pix("blink_on", 30, 200, 8'hFF, 1'b1);
`else
        pix("bracket", 30, 200, 8'hFF, 1'b1);
`endif
        pix("border_left", 0, 5, 8'hFC, 1'b0);
        pix("border_right", 635, 200, 8'hFC, 1'b0);
        pix("clip_x", 640, 200, 8'h58, 1'b0);
        pix("clip_y", 30, 480, 8'h58, 1'b0);

        // Matrix in static mode
        pix("m1_cell", 117, 125, 8'h32, 1'b0);
        pix("m1_left_edge", 100, 125, 8'h58, 1'b0);
        pix("m1_last_cell", 227, 125, 8'h3F, 1'b0);
        pix("m1_right_edge", 228, 125, 8'h58, 1'b0);
        pix("m1_origin", 101, 101, 8'h00, 1'b0);

        // Background-only mode
        change_mode(2'd0);
        pix("m0_no_matrix", 117, 125, 8'h58, 1'b0);
        pix("m0_bracket", 30, 200, 8'hFF, 1'b1);

        // Scrolling mode: offset steps once per 8 frames
        change_mode(2'd2);
        pix("m2_entry", 117, 125, 8'h32, 1'b0);
        repeat (7) new_frame();
        pix("m2_7frames", 117, 125, 8'h32, 1'b0);
        new_frame();
        pix("m2_8frames", 117, 125, 8'h33, 1'b0);

        // Request captured on the frame-start edge waits one more frame
        pixelX     = 11'd0;
        pixelY     = 11'd0;
        mode_req   = 2'd1;
        mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        chk("coinc_fs", 32'(frame_start), 32'd1);
        chk("coinc_ready", 32'(mode_ready), 32'd0);
        pixelX = 11'd5;
        pixelY = 11'd5;
        step();
        step();
        chk("coinc_ready_hold", 32'(mode_ready), 32'd0);
        pix("coinc_still_m2", 117, 125, 8'h33, 1'b0);
        new_frame();
        chk("coinc_ready_back", 32'(mode_ready), 32'd1);
        pix("coinc_now_m1", 117, 125, 8'h32, 1'b0);

        // Re-entering scrolling clears the offset; run it round the 8-bit wrap
        change_mode(2'd2);
        pix("m2_reentry", 101, 101, 8'h00, 1'b0);
        repeat (2040) new_frame();
        pix("m2_offset_255", 101, 101, 8'hFF, 1'b0);
        repeat (8) new_frame();
        pix("m2_offset_wrap", 101, 101, 8'h00, 1'b0);

        // Blank mode
        change_mode(2'd3);
        pix("m3_bracket", 30, 200, 8'h00, 1'b0);
        pix("m3_border", 0, 5, 8'h00, 1'b0);
        pix("m3_matrix", 117, 125, 8'h00, 1'b0);
        pix("m3_clip", 700, 700, 8'h00, 1'b0);

        // Reset mid-frame with a pending request
        change_mode(2'd0);
        pix("pre_rst_border", 0, 5, 8'hFC, 1'b0);
        mode_req   = 2'd3;
        mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        chk("pre_rst_pending", 32'(mode_ready), 32'd0);
        chk("pre_rst_rgb", 32'(BG_RGB), 32'hFC);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rgb", 32'(BG_RGB), 32'd0);
        chk("midrst_brd", 32'(boardersDrawReq), 32'd0);
        chk("midrst_ready", 32'(mode_ready), 32'd1);
        reset = 1'b0;
        step();
        pix("post_rst_mode1", 117, 125, 8'h32, 1'b0);
        new_frame();
        pix("post_rst_pend_dropped", 117, 125, 8'h32, 1'b0);
        chk("post_rst_ready", 32'(mode_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_pattern_gen.md
BG_PATTERN_GEN -- requirements
Module: bg_pattern_gen

Interface
REQ-001 SHALL have parameter FRAME_W, default 635, meaning the last visible X coordinate and the right frame border.
REQ-002 SHALL have parameter FRAME_H, default 475, meaning the last visible Y coordinate and the bottom frame border.
REQ-003 SHALL have parameter BRACKET_OFFSET, default 30, meaning the inset of the bracket lines from each frame border.
REQ-004 SHALL have parameter CELL_LOG2, default 3, meaning the matrix cell edge is 2^CELL_LOG2 pixels.
REQ-005 SHALL have parameter MATRIX_CELLS, default 16, meaning cells per matrix side (power of 2, maximum 16).
REQ-006 SHALL have parameters MATRIX_LEFT_X and MATRIX_TOP_Y, both default 100, meaning the matrix origin.
REQ-007 SHALL have parameter SCROLL_PERIOD, default 8, meaning frames per palette scroll step (range 1..255).
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have ports pixelX and pixelY, input, 11 bits each: the current raster coordinate.
REQ-011 SHALL have port mode_req, input, 2 bits: the requested display mode.
REQ-012 SHALL have port mode_valid (input, 1 bit) and port mode_ready (output, 1 bit): the mode request handshake.
REQ-013 SHALL have port BG_RGB, output, 8 bits: the pixel colour, RRRGGGBB.
REQ-014 SHALL have port boardersDrawReq, output, 1 bit: high while a bracket-line pixel is output.
REQ-015 SHALL have port frame_start, output, 1 bit: a one-cycle pulse at the start of each frame.

Function
REQ-016 SHALL pass every input coordinate through a 2-stage pipeline, so BG_RGB and boardersDrawReq correspond to the pixelX/pixelY sampled exactly 2 cycles earlier.
REQ-017 SHALL select pixel colour by priority, highest first:
- matrix region;
- bracket line, colour 8'hFF, boardersDrawReq=1;
- frame border, where x==0, y==0, x==FRAME_W or y==FRAME_H, colour 8'hFC;
- default fill, colour 8'h58.
REQ-018 SHALL define the matrix region with strict bounds: MATRIX_LEFT_X < x < MATRIX_LEFT_X + (MATRIX_CELLS<<CELL_LOG2), and the same form in Y.
REQ-019 SHALL compute the cell indices as cx=(x-MATRIX_LEFT_X)>>CELL_LOG2 and cy likewise in Y, each zero-extended to 4 bits.
REQ-020 SHALL compute the matrix colour as {cy[3:0],cx[3:0]} + scroll_offset, modulo 256.
REQ-021 SHALL support four modes: 0 background only (matrix disabled), 1 static matrix (scroll_offset forced 0), 2 scrolling matrix, 3 blank (BG_RGB=0, boardersDrawReq=0).
REQ-022 SHALL assert frame_start for one cycle when the sampled coordinate is (0,0) and the previously sampled coordinate was not; frame_start SHALL be aligned with stage 1, i.e. 1 cycle after the input.
REQ-023 SHALL, in mode 2, increment frame_cnt (8 bits) on each frame_start; on reaching SCROLL_PERIOD-1 it SHALL wrap to 0 and increment scroll_offset modulo 256.
REQ-024 SHALL hold frame_cnt and scroll_offset frozen in all modes other than 2.
REQ-025 SHALL capture mode_req into a pending register when mode_valid && mode_ready, and drop mode_ready on the next cycle.
REQ-026 SHALL apply the pending mode at the next frame_start and re-assert mode_ready on the cycle after it is applied; a capture coincident with a frame_start SHALL be applied at the following frame_start.
REQ-027 SHALL clear scroll_offset and frame_cnt when the mode changes into 2 from any other mode.
REQ-028 SHALL ignore mode_valid while mode_ready is low, leaving the pending request unchanged.
REQ-029 SHALL clip coordinates beyond FRAME_W or FRAME_H to default fill, with no border or matrix drawn there.

Reset
REQ-030 SHALL, on reset, immediately force BG_RGB=0, boardersDrawReq=0, frame_start=0, mode_ready=1, mode=1, with no pending request and scroll_offset, frame_cnt and all pipeline flags zero.
REQ-031 SHALL discard a pending mode and any in-flight pipeline data when reset asserts mid-frame; output resumes 2 cycles after reset deasserts.

Configuration
REQ-032 SHALL, when BG_BLINK_EN is defined, include a 5-bit blink counter incremented on every frame_start; bracket lines are drawn only while counter bit 4 is 1, and otherwise those pixels fall through to the lower priorities with boardersDrawReq=0.
REQ-033 SHALL, when BG_BLINK_EN is undefined, contain no blink counter and always draw bracket lines.

Verification
REQ-034 SHALL cover: after reset, drive (30,200) -> 2 cycles later BG_RGB=8'hFF and boardersDrawReq=1; drive (0,5) -> BG_RGB=8'hFC.
REQ-035 SHALL cover: mode 1, drive (117,125) -> cx=2, cy=3, BG_RGB=8'h32; drive (100,125) -> default fill 8'h58.
REQ-036 SHALL cover: request mode 2 mid-frame -> mode_ready=0 until the frame_start after the request plus 1 cycle; after 8 further frames, (117,125) gives 8'h33.
REQ-037 SHALL cover: run 2048 frames in mode 2 -> scroll_offset wraps 255->0 and matrix colour (101,101) returns to 8'h00.
REQ-038 SHALL cover: mode 3 -> every pixel 8'h00 and boardersDrawReq=0; assert reset mid-frame -> outputs 0 immediately and mode returns to 1.
REQ-039 SHALL cover, with BG_BLINK_EN defined: frames 0-15 show no bracket, with (30,200) giving 8'h58; frames 16-31 give 8'hFF with boardersDrawReq=1.
